// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per BUSY cycle, result valid WIDTH/CHUNK edges after accept.
// in_ready_o is low in BUSY/DONE; the result, flags and out_valid_o hold while out_ready_i is low.
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   out_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH:0]   out_q, out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] ch_a, ch_b;
  logic [CHUNK:0]   ch_res;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ch_a    = '0;
    ch_b    = '0;

    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IW'(i)) begin
        ch_a = a_q[i*CHUNK +: CHUNK];
        ch_b = b_q[i*CHUNK +: CHUNK];
      end
    end
    ch_res = {1'b0, ch_a} + {1'b0, ch_b} + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          // Subtract is A + ~B + 1: invert B once here and seed the carry with mode.
          a_d     = a_i;
          b_d     = mode_i ? ~b_i : b_i;
          carry_d = mode_i;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < NCH; i++) begin
          if (idx_q == IW'(i)) sum_d[i*CHUNK +: CHUNK] = ch_res[CHUNK-1:0];
        end
        carry_d = ch_res[CHUNK];
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NCH - 1)) begin
          state_d = DONE;
          out_d   = {ch_res[CHUNK], sum_d};
          zero_d  = (sum_d == '0);
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == DONE);
  assign out_o       = out_q;
  assign zero_o      = zero_q;
  assign ovf_o       = ovf_q;

endmodule
